// File: rtl/l1_trig_register_if.sv
// Trigger/readout bus for l1_trig_register: trigger-block inputs, readout pop port and status outputs.
// master drives Trig_In/Bcr/Ecr/Rd_En; slave (the register) returns data, flags and counters.
interface l1_trig_register_if #(
  parameter int DEPTH  = 16,
  parameter int BCID_W = 8,
  parameter int L1ID_W = 5
);
  logic                      Trig_In;
  logic                      Bcr;
  logic                      Ecr;
  logic                      Rd_En;
  logic [L1ID_W+BCID_W-1:0]  Rd_Data;
  logic                      Rd_Valid;
  logic                      L1_Reg_Full;
  logic                      L1_Reg_Empty;
  logic [$clog2(DEPTH):0]    Fill_Level;
  logic [7:0]                Ovfl_Count;

  modport master (
    output Trig_In, Bcr, Ecr, Rd_En,
    input  Rd_Data, Rd_Valid, L1_Reg_Full, L1_Reg_Empty, Fill_Level, Ovfl_Count
  );

  modport slave (
    input  Trig_In, Bcr, Ecr, Rd_En,
    output Rd_Data, Rd_Valid, L1_Reg_Full, L1_Reg_Empty, Fill_Level, Ovfl_Count
  );
endinterface

// File: rtl/l1_trig_register.sv
// Captures {L1ID,BCID} per trigger cycle into a FIFO; popped data is registered 1 cycle after Rd_En.
// Backpressure via registered L1_Reg_Full (overflow dropped and counted); TRIG_TMR_EN triplicates control state.
module l1_trig_register #(
  parameter int DEPTH  = 16,
  parameter int BCID_W = 8,
  parameter int L1ID_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  l1_trig_register_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          DW       = L1ID_W + BCID_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [BCID_W-1:0] bcid;
    logic [L1ID_W-1:0] l1id;
    logic [7:0]        ovfl;
    logic              full;
    logic              empty;
    logic              trig_hist;
  } state_t;

  function automatic state_t reset_state();
    state_t s;
    s       = '0;
    s.empty = 1'b1;
    return s;
  endfunction

  state_t        st;
  state_t        st_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          push_req, push, pop, ovfl_inc, trig_fall;

  // Full/empty decisions use pre-edge count, so a same-cycle pop never frees a slot for a push.
  always_comb begin
    push_req  = bus.Trig_In && !bus.Ecr;
    push      = push_req && (st.count != FULL_CNT);
    ovfl_inc  = push_req && (st.count == FULL_CNT);
    pop       = bus.Rd_En && !bus.Ecr && (st.count != '0);
    trig_fall = !bus.Trig_In && st.trig_hist;
  end

  always_comb begin
    st_d           = st;
    st_d.trig_hist = bus.Trig_In;
    st_d.bcid      = bus.Bcr ? '0 : st.bcid + BCID_W'(1);
    if (bus.Ecr) begin
      st_d.wr_ptr = '0;
      st_d.rd_ptr = '0;
      st_d.count  = '0;
      st_d.l1id   = '0;
      st_d.ovfl   = '0;
    end else begin
      if (push) begin
        st_d.wr_ptr = st.wr_ptr + AW'(1);
      end
      if (pop) begin
        st_d.rd_ptr = st.rd_ptr + AW'(1);
      end
      st_d.count = st.count + (AW+1)'(push) - (AW+1)'(pop);
      if (trig_fall) begin
        st_d.l1id = st.l1id + L1ID_W'(1);
      end
      if (ovfl_inc && (st.ovfl != 8'hFF)) begin
        st_d.ovfl = st.ovfl + 8'd1;
      end
    end
    st_d.full  = (st_d.count == FULL_CNT);
    st_d.empty = (st_d.count == '0);
  end

`ifdef TRIG_TMR_EN
  state_t tmr_q [3];

  // Every copy reloads the voted next state, so one upset copy heals on the following edge.
  always_comb begin
    st = state_t'((tmr_q[0] & tmr_q[1]) | (tmr_q[1] & tmr_q[2]) | (tmr_q[0] & tmr_q[2]));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) begin
        tmr_q[i] <= reset_state();
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        tmr_q[i] <= st_d;
      end
    end
  end
`else
  state_t st_q;

  always_comb begin
    st = st_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st_q <= reset_state();
    end else begin
      st_q <= st_d;
    end
  end
`endif

  always_comb begin
    rd_valid_d = pop;
    rd_data_d  = pop ? mem_q[st.rd_ptr] : rd_data_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage carries no reset: pointers and count alone decide what is readable.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[st.wr_ptr] <= {st.l1id, st.bcid};
    end
  end

  assign bus.Rd_Data      = rd_data_q;
  assign bus.Rd_Valid     = rd_valid_q;
  assign bus.L1_Reg_Full  = st.full;
  assign bus.L1_Reg_Empty = st.empty;
  assign bus.Fill_Level   = st.count;
  assign bus.Ovfl_Count   = st.ovfl;
endmodule

// File: tb/tb_l1_trig_register.sv
// Directed plus randomized bench for l1_trig_register against a queue-based reference model.
module tb_l1_trig_register;
  localparam int DEPTH  = 16;
  localparam int BCID_W = 8;
  localparam int L1ID_W = 5;
  localparam int DW     = L1ID_W + BCID_W;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  l1_trig_register_if #(.DEPTH(DEPTH), .BCID_W(BCID_W), .L1ID_W(L1ID_W)) bus ();

  l1_trig_register #(.DEPTH(DEPTH), .BCID_W(BCID_W), .L1ID_W(L1ID_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: entry queue plus plain integer counters.
  logic [DW-1:0] m_q [$];
  int            m_bcid, m_l1id, m_ovfl, m_wr;
  bit            m_hist, m_vld;
  logic [DW-1:0] m_data;
  logic [DW-1:0] exp_first;
  logic [DW-1:0] rd_tmp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rd_valid", 32'(bus.Rd_Valid), 32'(m_vld));
    check("rd_data", 32'(bus.Rd_Data), 32'(m_data));
    check("fill_level", 32'(bus.Fill_Level), m_q.size());
    check("full", 32'(bus.L1_Reg_Full), 32'(m_q.size() == DEPTH));
    check("empty", 32'(bus.L1_Reg_Empty), 32'(m_q.size() == 0));
    check("ovfl_count", 32'(bus.Ovfl_Count), m_ovfl);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bcid = 0; m_l1id = 0; m_ovfl = 0; m_wr = 0;
    m_hist = 1'b0; m_vld = 1'b0; m_data = '0;
  endtask

  task automatic model_edge(input bit t, input bit b, input bit e, input bit r);
    int            sz;
    logic [DW-1:0] ent;
    sz  = m_q.size();
    ent = {m_l1id[L1ID_W-1:0], m_bcid[BCID_W-1:0]};
    if (e) begin
      m_q.delete();
      m_ovfl = 0;
      m_vld  = 1'b0;
      m_wr   = 0;
      m_l1id = 0;
    end else begin
      m_vld = r && (sz > 0);
      if (m_vld) m_data = m_q.pop_front();
      if (t) begin
        if (sz < DEPTH) begin
          m_q.push_back(ent);
          m_wr = (m_wr + 1) % DEPTH;
        end else if (m_ovfl < 255) begin
          m_ovfl++;
        end
      end
      if (!t && m_hist) m_l1id = (m_l1id + 1) % (1 << L1ID_W);
    end
    m_hist = t;
    m_bcid = b ? 0 : (m_bcid + 1) % (1 << BCID_W);
  endtask

  task automatic step(input bit t, input bit b, input bit e, input bit r);
    bus.Trig_In = t; bus.Bcr = b; bus.Ecr = e; bus.Rd_En = r;
    @(posedge Clk);
    if (Reset) model_edge(t, b, e, r);
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && m_q.size() > 0; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    #2;
    Reset = 1'b0;
    bus.Trig_In = 1'b0; bus.Bcr = 1'b0; bus.Ecr = 1'b0; bus.Rd_En = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge Clk);
    #1 check_all();
    Reset = 1'b1;
  endtask

  initial begin
    bus.Trig_In = 1'b0; bus.Bcr = 1'b0; bus.Ecr = 1'b0; bus.Rd_En = 1'b0;
    model_reset();

    // Reset held three cycles, then released between edges.
    repeat (3) @(posedge Clk);
    #1 check_all();
    Reset = 1'b1;
    #1;
    check("rst_empty", 32'(bus.L1_Reg_Empty), 32'd1);
    check("rst_full", 32'(bus.L1_Reg_Full), 32'd0);
    check("rst_valid", 32'(bus.Rd_Valid), 32'd0);
    check("rst_fill", 32'(bus.Fill_Level), 32'd0);
    check("rst_ovfl", 32'(bus.Ovfl_Count), 32'd0);

    // First burst at BCID 10..12, second burst at BCID 40.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("t2_valid", 32'(bus.Rd_Valid), 32'd1);
      check("t2_data", 32'(bus.Rd_Data), 32'(10 + i));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_valid_drop", 32'(bus.Rd_Valid), 32'd0);
    for (int i = 0; i < 300 && m_bcid != 40; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_burst2", 32'(bus.Rd_Data), 32'h128);

    // Fill to DEPTH, overflow twice, then one pop returns the oldest entry.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_first = {m_l1id[L1ID_W-1:0], m_bcid[BCID_W-1:0]};
    repeat (DEPTH) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_full", 32'(bus.L1_Reg_Full), 32'd1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_ovfl", 32'(bus.Ovfl_Count), 32'd2);
    check("t3_fill", 32'(bus.Fill_Level), 32'd16);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_unfull", 32'(bus.L1_Reg_Full), 32'd0);
    check("t3_first", 32'(bus.Rd_Data), 32'(exp_first));
    drain();

    // Simultaneous push/pop at count 5, then pop-on-empty with a push.
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_fill", 32'(bus.Fill_Level), 32'd5);
    check("t4_valid", 32'(bus.Rd_Valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_empty_valid", 32'(bus.Rd_Valid), 32'd0);
    check("t4_empty_fill", 32'(bus.Fill_Level), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Bring overflow to 3, then Ecr in the middle of a 4-trigger burst.
    repeat (DEPTH + 1) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_pre_fill", 32'(bus.Fill_Level), 32'd2);
    check("t5_pre_ovfl", 32'(bus.Ovfl_Count), 32'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_ecr_empty", 32'(bus.L1_Reg_Empty), 32'd1);
    check("t5_ecr_ovfl", 32'(bus.Ovfl_Count), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_post_fill", 32'(bus.Fill_Level), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    rd_tmp = bus.Rd_Data;
    check("t5_l1id", 32'(rd_tmp[DW-1:BCID_W]), 32'd0);
    for (int i = 0; i < 300 && m_bcid != 255; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    rd_tmp = bus.Rd_Data;
    check("t5_bcid255", 32'(rd_tmp[BCID_W-1:0]), 32'd255);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    rd_tmp = bus.Rd_Data;
    check("t5_bcid_wrap", 32'(rd_tmp[BCID_W-1:0]), 32'd0);

    // Asynchronous reset in the middle of a burst.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    check("mid_rst_fill", 32'(bus.Fill_Level), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic: fill-biased half, then drain-biased half, with one reset between.
    for (int i = 0; i < 1600; i++) begin
      if (i == 800) pulse_reset();
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 2,
           $urandom_range(0, 299) < 1, $urandom_range(0, 99) < ((i < 800) ? 35 : 70));
    end

`ifdef TRIG_TMR_EN
    // Upset one copy of the write pointer; the vote masks it and the copy heals.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    force dut.tmr_q[1].wr_ptr = 4'd9;
    #4;
    release dut.tmr_q[1].wr_ptr;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("tmr_heal", 32'(dut.tmr_q[1].wr_ptr), m_wr);
    check("tmr_fill", 32'(bus.Fill_Level), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
